sram_fifo_ctrl: RTL and testbench

Streaming FIFO controller that sits directly upstream of the 16384 x 16 1R1W SRAM macro (`sram_1R1W` instance) and owns both of its ports. It accepts words on a valid/ready input stream and writes them into the SRAM. It reads them back in order into a registered output stage and presents them on a valid/ready output stream. Total capacity is DEPTH + 1 words: DEPTH in the SRAM plus one in the output register.

---
 rtl/sram_fifo_ctrl.sv | 104 ++++++++++
 tb/tb_sram_fifo_ctrl.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_fifo_ctrl.sv
// sram_fifo_ctrl: streaming FIFO controller in front of a 1R1W SRAM macro.
// Words are written into the SRAM as they are accepted and read back in order
// into a single registered output stage. The SRAM read port is asynchronous, so
// the read pointer feeds the macro directly and the returned word is captured
// into the output register on the same edge the pointer advances.
// Capacity is DEPTH words in the SRAM plus one word in the output register.
module sram_fifo_ctrl #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 16,
  parameter int DEPTH  = 2 ** ADDR_W
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              empty,
  output logic              sram_we,
  output logic [ADDR_W-1:0] sram_waddr,
  output logic [DATA_W-1:0] sram_wdata,
  output logic [ADDR_W-1:0] sram_raddr,
  input  logic [DATA_W-1:0] sram_rdata
);

  localparam logic [ADDR_W:0] MemFull = (ADDR_W + 1)'(DEPTH);

  logic [ADDR_W-1:0] wrPtr;
  logic [ADDR_W-1:0] rdPtr;
  logic [ADDR_W:0]   memCnt;
  logic              push;
  logic              load;
  logic              pop;

  // Handshake decisions depend only on registered state, so in_ready never
  // combinationally follows in_valid. Holding in_ready low during reset keeps
  // the SRAM write enable quiet while reset_n is asserted.
  assign in_ready = reset_n && (memCnt != MemFull);
  assign push     = in_valid && in_ready;
  assign load     = (memCnt != '0) && (!out_valid || out_ready);
  assign pop      = out_valid && out_ready;

  // The SRAM captures the incoming word on the same edge that accepts it.
  // A word written on an edge is only counted in memCnt afterwards, so it can
  // never be read on that edge and no write-to-read bypass is required.
  assign sram_we    = push;
  assign sram_waddr = wrPtr;
  assign sram_wdata = in_data;
  assign sram_raddr = rdPtr;

  assign count = memCnt + {{ADDR_W{1'b0}}, out_valid};
  assign full  = (memCnt == MemFull);
  assign empty = !out_valid;

  // Write and read pointers advance on push and load and wrap naturally
  // because DEPTH is a power of two.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wrPtr <= '0;
      rdPtr <= '0;
    end else begin
      if (push) begin
        wrPtr <= wrPtr + ADDR_W'(1);
      end
      if (load) begin
        rdPtr <= rdPtr + ADDR_W'(1);
      end
    end
  end

  // Occupancy of the SRAM alone; a simultaneous push and load cancel out.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      memCnt <= '0;
    end else begin
      case ({push, load})
        2'b10:   memCnt <= memCnt + (ADDR_W + 1)'(1);
        2'b01:   memCnt <= memCnt - (ADDR_W + 1)'(1);
        default: memCnt <= memCnt;
      endcase
    end
  end

  // Output stage refills from the SRAM whenever it is empty or being drained,
  // and holds its word steady while the consumer stalls.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      if (load) begin
        out_data  <= sram_rdata;
        out_valid <= 1'b1;
      end else if (pop) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sram_fifo_ctrl.sv
// tb_sram_fifo_ctrl: drives sram_fifo_ctrl against a behavioural SRAM and a
// queue-based reference model of the FIFO contents and its output register.
module tb_sram_fifo_ctrl;

  localparam int ADDR_W = 14;
  localparam int DATA_W = 16;
  localparam int DEPTH  = 1 << ADDR_W;

  logic              clock = 1'b0;
  logic              reset_n;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [ADDR_W:0]   count;
  logic              full;
  logic              empty;
  logic              sram_we;
  logic [ADDR_W-1:0] sram_waddr;
  logic [DATA_W-1:0] sram_wdata;
  logic [ADDR_W-1:0] sram_raddr;
  logic [DATA_W-1:0] sram_rdata;

  // Reference model: words held in the SRAM, the output register and the
  // running totals of writes and reads that define the expected addresses.
  logic [DATA_W-1:0] memQ[$];
  logic              ovM;
  logic [DATA_W-1:0] odM;
  int                wrCnt;
  int                rdCnt;
  int                errors = 0;
  int                checks = 0;

  logic [DATA_W-1:0] sramMem [DEPTH];

  sram_fifo_ctrl #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W),
    .DEPTH (DEPTH)
  ) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .count     (count),
    .full      (full),
    .empty     (empty),
    .sram_we   (sram_we),
    .sram_waddr(sram_waddr),
    .sram_wdata(sram_wdata),
    .sram_raddr(sram_raddr),
    .sram_rdata(sram_rdata)
  );

  // 10 ns clock
  always #5 clock = ~clock;

  // Behavioural 1R1W SRAM: synchronous write, asynchronous read
  always @(posedge clock) begin
    if (sram_we) begin
      sramMem[sram_waddr] <= sram_wdata;
    end
  end

  assign sram_rdata = sramMem[sram_raddr];

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, actual, expected, $time);
    end
  endtask

  task automatic modelReset();
    memQ.delete();
    ovM   = 1'b0;
    odM   = '0;
    wrCnt = 0;
    rdCnt = 0;
  endtask

  // Compare all registered outputs against the model
  task automatic checkState();
    checkOutput("in_ready",  32'(in_ready),  32'(memQ.size() != DEPTH));
    checkOutput("out_valid", 32'(out_valid), 32'(ovM));
    checkOutput("out_data",  32'(out_data),  32'(odM));
    checkOutput("count",     32'(count),     32'(memQ.size() + int'(ovM)));
    checkOutput("full",      32'(full),      32'(memQ.size() == DEPTH));
    checkOutput("empty",     32'(empty),     32'(!ovM));
    checkOutput("raddr",     32'(sram_raddr), 32'(rdCnt % DEPTH));
  endtask

  // One clock cycle: drive inputs after a falling edge, check the write port,
  // advance the model on the rising edge, then check state at the next fall.
  task automatic applyStimulus(input logic v, input logic [DATA_W-1:0] d, input logic r);
    logic pushOk;
    logic loadOk;
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    #1;
    pushOk = v && (memQ.size() != DEPTH);
    loadOk = (memQ.size() != 0) && (!ovM || r);
    checkOutput("sram_we", 32'(sram_we), 32'(pushOk));
    if (pushOk) begin
      checkOutput("waddr", 32'(sram_waddr), 32'(wrCnt % DEPTH));
      checkOutput("wdata", 32'(sram_wdata), 32'(d));
    end
    @(posedge clock);
    if (loadOk) begin
      odM = memQ.pop_front();
      ovM = 1'b1;
      rdCnt++;
    end else if (ovM && r) begin
      ovM = 1'b0;
    end
    if (pushOk) begin
      memQ.push_back(d);
      wrCnt++;
    end
    @(negedge clock);
    checkState();
  endtask

  // Asynchronous reset asserted between edges while a push is being offered
  task automatic doReset();
    in_valid  = 1'b1;
    in_data   = 16'h5555;
    out_ready = 1'b1;
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("rstOutValid", 32'(out_valid), 32'd0);
    checkOutput("rstCount",    32'(count),     32'd0);
    checkOutput("rstInReady",  32'(in_ready),  32'd0);
    checkOutput("rstSramWe",   32'(sram_we),   32'd0);
    checkOutput("rstOutData",  32'(out_data),  32'd0);
    checkOutput("rstRaddr",    32'(sram_raddr), 32'd0);
    modelReset();
    in_valid = 1'b0;
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    #1;
    checkState();
  endtask

  initial begin
    int pv;
    int pr;
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    modelReset();
    #2;
    checkOutput("initOutValid", 32'(out_valid), 32'd0);
    checkOutput("initCount",    32'(count),     32'd0);
    checkOutput("initInReady",  32'(in_ready),  32'd0);
    checkOutput("initSramWe",   32'(sram_we),   32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    #1;
    checkState();

    // Single word latency and drain
    applyStimulus(1'b1, 16'hA5A5, 1'b1);
    checkOutput("singleNotYet", 32'(out_valid), 32'd0);
    applyStimulus(1'b0, 16'h0000, 1'b1);
    checkOutput("singleValid", 32'(out_valid), 32'd1);
    checkOutput("singleData",  32'(out_data),  32'hA5A5);
    applyStimulus(1'b0, 16'h0000, 1'b1);
    checkOutput("singleEmpty", 32'(empty), 32'd1);

    // Fill to capacity with the consumer stalled, then try one extra push
    for (int i = 0; i <= DEPTH; i++) begin
      applyStimulus(1'b1, 16'(i), 1'b0);
    end
    checkOutput("fillFull",    32'(full),     32'd1);
    checkOutput("fillCount",   32'(count),    32'(DEPTH + 1));
    checkOutput("fillInReady", 32'(in_ready), 32'd0);
    applyStimulus(1'b1, 16'hFFFF, 1'b0);
    checkOutput("fillBlocked", 32'(count), 32'(DEPTH + 1));

    // Push and pop together while full: only the pop happens, freeing a slot
    applyStimulus(1'b1, 16'hBEEF, 1'b1);
    checkOutput("fullPopReady", 32'(in_ready), 32'd1);
    checkOutput("fullPopData",  32'(out_data), 32'd1);

    // Drain everything in order
    for (int i = 0; i < DEPTH + 4; i++) begin
      applyStimulus(1'b0, 16'h0000, 1'b1);
    end
    checkOutput("drainEmpty", 32'(empty), 32'd1);
    checkOutput("drainCount", 32'(count), 32'd0);

    // Simultaneous push and pop with only the output register occupied
    applyStimulus(1'b1, 16'h1111, 1'b0);
    applyStimulus(1'b0, 16'h0000, 1'b0);
    checkOutput("oneCount", 32'(count), 32'd1);
    applyStimulus(1'b1, 16'h2222, 1'b1);
    checkOutput("oneBubble", 32'(out_valid), 32'd0);
    applyStimulus(1'b0, 16'h0000, 1'b0);
    checkOutput("oneNewValid", 32'(out_valid), 32'd1);
    checkOutput("oneNewData",  32'(out_data),  32'h2222);
    applyStimulus(1'b0, 16'h0000, 1'b1);
    applyStimulus(1'b0, 16'h0000, 1'b1);

    // Continuous streaming across the pointer wrap
    for (int i = 0; i < 17000; i++) begin
      applyStimulus(1'b1, 16'(i + 16'h0100), 1'b1);
    end

    // Reset in the middle of random traffic, then a clean first word
    for (int i = 0; i < 200; i++) begin
      applyStimulus(1'($urandom_range(0, 1)), 16'($urandom), 1'($urandom_range(0, 1)));
    end
    doReset();
    applyStimulus(1'b1, 16'h1234, 1'b1);
    checkOutput("postRstNoStale", 32'(out_valid), 32'd0);
    applyStimulus(1'b0, 16'h0000, 1'b0);
    checkOutput("postRstValid", 32'(out_valid), 32'd1);
    checkOutput("postRstData",  32'(out_data),  32'h1234);

    // Randomized backpressure with changing producer/consumer rates
    for (int p = 0; p < 15; p++) begin
      pv = $urandom_range(20, 100);
      pr = $urandom_range(10, 100);
      for (int i = 0; i < 1000; i++) begin
        applyStimulus(1'($urandom_range(0, 99) < pv), 16'($urandom),
                      1'($urandom_range(0, 99) < pr));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
